// File: rtl/lcd_show_char.sv
`default_nettype none
// lcd_show_char: renders one 16x8 or 12x6 glyph (font ROM -> 0x2A/0x2B/0x2C window -> RGB565 bytes).
// Optional macro SHOW_CHAR_INVERT_EN adds an `invert` input that swaps colours per character.
module lcd_show_char #(
  parameter logic [15:0] FG_COLOR   = 16'h0000,
  parameter logic [15:0] BG_COLOR   = 16'hFFFF,
  parameter int          ROM_LAT    = 1,
  parameter int          SMALL_BASE = 1536
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        show_char_flag,
  input  logic [6:0]  ascii_num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
  input  logic        en_size,
`ifdef SHOW_CHAR_INVERT_EN
  input  logic        invert,
`endif
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        wr_en,
  output logic        wr_dc,
  output logic [7:0]  wr_byte,
  input  logic        wr_done,
  output logic        busy,
  output logic        show_char_done
);

  localparam logic [11:0] SMALL_BASE_A = SMALL_BASE[11:0];
  localparam logic [1:0]  LAT          = ROM_LAT[1:0];

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ROM  = 3'd2,
    S_PIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  ascii_q, ascii_d;
  logic [8:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        large_q, large_d;
  logic        inv_q, inv_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic        half_q, half_d;
  logic        wait_q, wait_d;
  logic [1:0]  lat_q, lat_d;
  logic [7:0]  row_data_q, row_data_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic        wr_en_q, wr_en_d;
  logic        wr_dc_q, wr_dc_d;
  logic [7:0]  wr_byte_q, wr_byte_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        inv_in;
  logic [2:0]  col_last;
  logic [3:0]  row_last;
  logic [15:0] xs, xe, ys, ye;
  logic [7:0]  cmd_byte;
  logic        cmd_dc;
  logic        pix_fg;
  logic [15:0] pix_color;
  logic [7:0]  pix_byte;

`ifdef SHOW_CHAR_INVERT_EN
  assign inv_in = invert;
`else
  assign inv_in = 1'b0;
`endif

  assign col_last = large_q ? 3'd7 : 3'd5;
  assign row_last = large_q ? 4'd15 : 4'd11;
  assign xs = {7'd0, x_q};
  assign ys = {7'd0, y_q};
  assign xe = xs + (large_q ? 16'd7 : 16'd5);
  assign ye = ys + (large_q ? 16'd15 : 16'd11);

  // Large glyphs live at ascii*16; small glyphs at SMALL_BASE + ascii*12.
  function automatic logic [11:0] addr_of(input logic [6:0] a, input logic lg,
                                          input logic [3:0] r);
    if (lg) addr_of = {1'b0, a, 4'd0} + {8'd0, r};
    else    addr_of = SMALL_BASE_A + {2'd0, a, 3'd0} + {3'd0, a, 2'd0} + {8'd0, r};
  endfunction

  always_comb begin
    cmd_byte = 8'h00;
    case (idx_q)
      4'd0:    cmd_byte = 8'h2A;
      4'd1:    cmd_byte = xs[15:8];
      4'd2:    cmd_byte = xs[7:0];
      4'd3:    cmd_byte = xe[15:8];
      4'd4:    cmd_byte = xe[7:0];
      4'd5:    cmd_byte = 8'h2B;
      4'd6:    cmd_byte = ys[15:8];
      4'd7:    cmd_byte = ys[7:0];
      4'd8:    cmd_byte = ye[15:8];
      4'd9:    cmd_byte = ye[7:0];
      4'd10:   cmd_byte = 8'h2C;
      default: cmd_byte = 8'h00;
    endcase
  end

  assign cmd_dc    = !((idx_q == 4'd0) || (idx_q == 4'd5) || (idx_q == 4'd10));
  assign pix_fg    = row_data_q[3'd7 - col_q] ^ inv_q;
  assign pix_color = pix_fg ? FG_COLOR : BG_COLOR;
  assign pix_byte  = half_q ? pix_color[7:0] : pix_color[15:8];

  always_comb begin
    state_d    = state_q;
    ascii_d    = ascii_q;
    x_d        = x_q;
    y_d        = y_q;
    large_d    = large_q;
    inv_d      = inv_q;
    idx_d      = idx_q;
    row_d      = row_q;
    col_d      = col_q;
    half_d     = half_q;
    wait_d     = wait_q;
    lat_d      = lat_q;
    row_data_d = row_data_q;
    rom_addr_d = rom_addr_q;
    wr_en_d    = 1'b0;
    wr_dc_d    = wr_dc_q;
    wr_byte_d  = wr_byte_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (show_char_flag) begin
          ascii_d = ascii_num;
          x_d     = start_x;
          y_d     = start_y;
          large_d = en_size;
          inv_d   = inv_in;
          idx_d   = 4'd0;
          wait_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        if (!wait_q) begin
          wr_en_d   = 1'b1;
          wr_byte_d = cmd_byte;
          wr_dc_d   = cmd_dc;
          wait_d    = 1'b1;
        end else if (wr_done) begin
          wait_d = 1'b0;
          if (idx_q == 4'd10) begin
            row_d      = 4'd0;
            rom_addr_d = addr_of(ascii_q, large_q, 4'd0);
            lat_d      = 2'd0;
            state_d    = S_ROM;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      // rom_addr_q is valid from the first S_ROM cycle; sample ROM_LAT cycles later.
      S_ROM: begin
        lat_d = lat_q + 2'd1;
        if (lat_q == LAT) begin
          row_data_d = rom_data;
          col_d      = 3'd0;
          half_d     = 1'b0;
          wait_d     = 1'b0;
          state_d    = S_PIX;
        end
      end

      S_PIX: begin
        if (!wait_q) begin
          wr_en_d   = 1'b1;
          wr_byte_d = pix_byte;
          wr_dc_d   = 1'b1;
          wait_d    = 1'b1;
        end else if (wr_done) begin
          wait_d = 1'b0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (col_q != col_last) begin
              col_d = col_q + 3'd1;
            end else if (row_q == row_last) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              row_d      = row_q + 4'd1;
              rom_addr_d = addr_of(ascii_q, large_q, row_q + 4'd1);
              lat_d      = 2'd0;
              state_d    = S_ROM;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      ascii_q    <= 7'd0;
      x_q        <= 9'd0;
      y_q        <= 9'd0;
      large_q    <= 1'b0;
      inv_q      <= 1'b0;
      idx_q      <= 4'd0;
      row_q      <= 4'd0;
      col_q      <= 3'd0;
      half_q     <= 1'b0;
      wait_q     <= 1'b0;
      lat_q      <= 2'd0;
      row_data_q <= 8'd0;
      rom_addr_q <= 12'd0;
      wr_en_q    <= 1'b0;
      wr_dc_q    <= 1'b0;
      wr_byte_q  <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ascii_q    <= ascii_d;
      x_q        <= x_d;
      y_q        <= y_d;
      large_q    <= large_d;
      inv_q      <= inv_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      half_q     <= half_d;
      wait_q     <= wait_d;
      lat_q      <= lat_d;
      row_data_q <= row_data_d;
      rom_addr_q <= rom_addr_d;
      wr_en_q    <= wr_en_d;
      wr_dc_q    <= wr_dc_d;
      wr_byte_q  <= wr_byte_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign wr_en          = wr_en_q;
  assign wr_dc          = wr_dc_q;
  assign wr_byte        = wr_byte_q;
  assign busy           = busy_q;
  assign show_char_done = done_q;

endmodule
`default_nettype wire
